popcount_window_stats: RTL and testbench

Windowed statistics stage placed directly downstream of the bit population counter. It consumes the counter's per-word result stream (count plus valid) and groups valid samples into windows of WINDOW samples. For each window it reports the sum, minimum, maximum and sample count as a registered result with a one-cycle valid pulse. A flush input closes a partial window early, for example at frame end.

---
 rtl/popcount_window_stats.sv | 95 +++++++++
 tb/tb_popcount_window_stats.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/popcount_window_stats.sv
// Windowed sum/min/max/count statistics over the valid popcount result stream.
// A window closes on reaching WINDOW samples or on flush; each close produces one registered result pulse.
module popcount_window_stats #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned WINDOW = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1,
  localparam int unsigned SUM_W = $clog2(WIDTH * WINDOW + 1),
  localparam int unsigned SMP_W = $clog2(WINDOW + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             data_val_i,
  input  logic             flush_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [SMP_W-1:0] samples_o,
  output logic             stats_val_o
);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t           state;
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_min;
  logic [CNT_W-1:0] acc_max;
  logic [SMP_W-1:0] acc_cnt;

  logic [CNT_W-1:0] d;
  logic [SUM_W-1:0] new_sum;
  logic [CNT_W-1:0] new_min;
  logic [CNT_W-1:0] new_max;
  logic [SMP_W-1:0] new_cnt;
  logic             close;

  // Window values including this cycle's sample; both close and accumulate paths use them.
  always_comb begin
    d       = (data_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : data_i;
    new_sum = acc_sum;
    new_min = acc_min;
    new_max = acc_max;
    new_cnt = acc_cnt;
    if (data_val_i) begin
      if (state == EMPTY) begin
        new_sum = SUM_W'(d);
        new_min = d;
        new_max = d;
        new_cnt = SMP_W'(1);
      end else begin
        new_sum = acc_sum + SUM_W'(d);
        new_min = (d < acc_min) ? d : acc_min;
        new_max = (d > acc_max) ? d : acc_max;
        new_cnt = acc_cnt + SMP_W'(1);
      end
    end
    close = (data_val_i && (new_cnt == SMP_W'(WINDOW))) ||
            (flush_i && ((state == ACCUM) || data_val_i));
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= EMPTY;
      acc_sum     <= '0;
      acc_min     <= '0;
      acc_max     <= '0;
      acc_cnt     <= '0;
      sum_o       <= '0;
      min_o       <= '0;
      max_o       <= '0;
      samples_o   <= '0;
      stats_val_o <= 1'b0;
    end else begin
      stats_val_o <= close;
      if (close) begin
        sum_o     <= new_sum;
        min_o     <= new_min;
        max_o     <= new_max;
        samples_o <= new_cnt;
        acc_sum   <= '0;
        acc_min   <= '0;
        acc_max   <= '0;
        acc_cnt   <= '0;
        state     <= EMPTY;
      end else if (data_val_i) begin
        acc_sum <= new_sum;
        acc_min <= new_min;
        acc_max <= new_max;
        acc_cnt <= new_cnt;
        state   <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_popcount_window_stats.sv
// Directed bench for popcount_window_stats with WIDTH=16, WINDOW=4.
module tb_popcount_window_stats;

  logic       clk;
  logic       arst;
  logic [4:0] data;
  logic       data_val;
  logic       flush;
  logic [6:0] sum;
  logic [4:0] min_v;
  logic [4:0] max_v;
  logic [2:0] samples;
  logic       stats_val;

  int errors = 0;
  int checks = 0;

  popcount_window_stats #(.WIDTH(16), .WINDOW(4)) dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .data_i     (data),
    .data_val_i (data_val),
    .flush_i    (flush),
    .sum_o      (sum),
    .min_o      (min_v),
    .max_o      (max_v),
    .samples_o  (samples),
    .stats_val_o(stats_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input int s, input int mn,
                           input int mx, input int n);
    check({tag, "_val"}, 32'(stats_val), 32'(v));
    check({tag, "_sum"}, 32'(sum), 32'(s));
    check({tag, "_min"}, 32'(min_v), 32'(mn));
    check({tag, "_max"}, 32'(max_v), 32'(mx));
    check({tag, "_samples"}, 32'(samples), 32'(n));
  endtask

  // Apply inputs, let one rising edge capture them, then sample 1 time unit later.
  task automatic drive(input logic v, input logic [4:0] d, input logic f);
    data_val = v;
    data     = d;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 1'b0);
      check(tag, 32'(stats_val), 32'd0);
    end
  endtask

  initial begin
    arst     = 1'b0;
    data     = '0;
    data_val = 1'b0;
    flush    = 1'b0;

    // Reset between edges
    #2 arst = 1'b1;
    #1 check_all("reset", 1'b0, 0, 0, 0, 0);
    #10 arst = 1'b0;
    idle_quiet("reset_idle", 10);

    // Full back-to-back window
    drive(1'b1, 5'd3, 1'b0);  check("full_s1", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd16, 1'b0); check("full_s2", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd0, 1'b0);  check("full_s3", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd7, 1'b0);  check_all("full", 1'b1, 26, 0, 16, 4);
    drive(1'b0, 5'd0, 1'b0);  check_all("full_hold", 1'b0, 26, 0, 16, 4);

    // Same window with gaps
    drive(1'b1, 5'd3, 1'b0);  check("gap_s1", 32'(stats_val), 32'd0);
    idle_quiet("gap_a", 1);
    drive(1'b1, 5'd16, 1'b0); check("gap_s2", 32'(stats_val), 32'd0);
    idle_quiet("gap_b", 2);
    drive(1'b1, 5'd0, 1'b0);  check("gap_s3", 32'(stats_val), 32'd0);
    idle_quiet("gap_c", 3);
    drive(1'b1, 5'd7, 1'b0);  check_all("gap", 1'b1, 26, 0, 16, 4);
    idle_quiet("gap_after", 1);

    // Flush after two samples
    drive(1'b1, 5'd5, 1'b0);
    drive(1'b1, 5'd9, 1'b0);  check("fl2_pre", 32'(stats_val), 32'd0);
    drive(1'b0, 5'd0, 1'b1);  check_all("fl2", 1'b1, 14, 5, 9, 2);

    // Flush while empty is ignored
    drive(1'b0, 5'd0, 1'b1);  check_all("fl_empty", 1'b0, 14, 5, 9, 2);

    // Flush together with a sample
    drive(1'b1, 5'd2, 1'b0);  check("flw_pre", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd4, 1'b1);  check_all("flw", 1'b1, 6, 2, 4, 2);

    // Flush coinciding with full close
    drive(1'b1, 5'd1, 1'b0);
    drive(1'b1, 5'd2, 1'b0);
    drive(1'b1, 5'd3, 1'b0);  check("flf_pre", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd4, 1'b1);  check_all("flf", 1'b1, 10, 1, 4, 4);
    idle_quiet("flf_single", 1);

    // Eight samples of 16 (one given as 17, saturated)
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 2) ? 5'd17 : 5'd16, 1'b0);
      if (i % 4 == 3) check_all($sformatf("sat_w%0d", i / 4), 1'b1, 64, 16, 16, 4);
      else            check($sformatf("sat_s%0d", i), 32'(stats_val), 32'd0);
    end
    idle_quiet("sat_after", 1);

    // Consecutive closes from single-sample flushes
    drive(1'b1, 5'd5, 1'b1);  check_all("cc1", 1'b1, 5, 5, 5, 1);
    drive(1'b1, 5'd9, 1'b1);  check_all("cc2", 1'b1, 9, 9, 9, 1);
    idle_quiet("cc_after", 1);

    // Async reset mid-window
    drive(1'b1, 5'd8, 1'b0);
    drive(1'b1, 5'd8, 1'b0);  check("rst_pre", 32'(stats_val), 32'd0);
    data_val = 1'b0;
    #3 arst = 1'b1;
    #1 check_all("rst_mid", 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    #2 arst = 1'b0;
    check("rst_mid_held", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd1, 1'b0);  check("post_s1", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd2, 1'b0);  check("post_s2", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd3, 1'b0);  check("post_s3", 32'(stats_val), 32'd0);
    drive(1'b1, 5'd4, 1'b0);  check_all("post", 1'b1, 10, 1, 4, 4);
    drive(1'b0, 5'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
